l2_mem_requester: RTL and testbench

- Memory-side initiator of the L2 cache: the master end of the read_L2_MEM/write_L2_MEM line-transfer interface.
- Takes one miss request from the L2 controller and, if the victim line is dirty, writes it back first.
- Then fetches the missed 512-bit line and returns it upstream with a one-cycle valid pulse.
- Sequences the request/ready handshake, guarantees mutually exclusive read/write strobes and enforces idle gaps between transfers.

---
 rtl/l2_mem_requester.sv | 156 +++++++++++++++
 tb/tb_l2_mem_requester.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_requester.sv
// l2_mem_requester: memory-side initiator of the L2 cache.
// Accepts one miss, writes back a dirty victim, waits GAP_CYC idle cycles,
// then fetches the missed line and returns it with a one-cycle refill_valid.
// Optional feature macro: L2_MEM_TIMEOUT_EN (watchdog on WB/RD, sticky timeout_err).
module l2_mem_requester #(
  parameter int TNUM        = 22,
  parameter int INUM        = 26 - TNUM,
  parameter int LINE_W      = 512,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              miss_req,
  input  logic [TNUM-1:0]   miss_tag,
  input  logic [INUM-1:0]   miss_index,
  input  logic              victim_dirty,
  input  logic [TNUM-1:0]   victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic              miss_busy,
  output logic              refill_valid,
  output logic [LINE_W-1:0] refill_data,
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [TNUM-1:0]   tag_L2_MEM,
  output logic [INUM-1:0]   index_L2_MEM,
  output logic [TNUM-1:0]   write_tag_L2_MEM,
  output logic [LINE_W-1:0] write_data_L2_MEM,
  input  logic              ready_MEM_L2,
  input  logic [LINE_W-1:0] read_data_MEM_L2,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, WB, GAP, RD, DONE} state_e;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e              state_q, state_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [TNUM-1:0]     tag_q, tag_d;
  logic [TNUM-1:0]     wtag_q, wtag_d;
  logic [INUM-1:0]     index_q, index_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   refill_q, refill_d;
  logic                timeout_hit;

`ifdef L2_MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Watchdog trips in the last allowed cycle of a transfer unless memory answers in it
  always_comb begin
    timeout_hit = ((state_q == WB) || (state_q == RD)) && !ready_MEM_L2 &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    to_cnt_d    = '0;
    if (((state_q == WB) || (state_q == RD)) && (state_d == state_q))
      to_cnt_d = to_cnt_q + 1'b1;
    to_err_d    = to_err_q | timeout_hit;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      tag_q     <= '0;
      wtag_q    <= '0;
      index_q   <= '0;
      wdata_q   <= '0;
      refill_q  <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      tag_q     <= tag_d;
      wtag_q    <= wtag_d;
      index_q   <= index_d;
      wdata_q   <= wdata_d;
      refill_q  <= refill_d;
    end
  end

  // Next-state logic; ready is honoured only in WB and RD
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    unique case (state_q)
      IDLE: if (miss_req) state_d = victim_dirty ? WB : RD;
      WB: begin
        if (ready_MEM_L2)     state_d = GAP;
        else if (timeout_hit) state_d = IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) state_d = RD;
        else                                  gap_cnt_d = gap_cnt_q + 1'b1;
      end
      RD: begin
        if (ready_MEM_L2)     state_d = DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured on acceptance and held, so the memory-side
  // address/data buses stay stable through the transfer and after it
  always_comb begin
    tag_d    = tag_q;
    wtag_d   = wtag_q;
    index_d  = index_q;
    wdata_d  = wdata_q;
    refill_d = refill_q;
    if ((state_q == IDLE) && miss_req) begin
      tag_d   = miss_tag;
      wtag_d  = victim_tag;
      index_d = miss_index;
      wdata_d = victim_data;
    end
    if ((state_q == RD) && ready_MEM_L2)
      refill_d = read_data_MEM_L2;
  end

  // Outputs decoded from state; strobes are mutually exclusive by construction
  always_comb begin
    miss_busy    = (state_q != IDLE);
    write_L2_MEM = (state_q == WB);
    read_L2_MEM  = (state_q == RD);
    refill_valid = (state_q == DONE);
  end

  assign refill_data       = refill_q;
  assign tag_L2_MEM        = tag_q;
  assign index_L2_MEM      = index_q;
  assign write_tag_L2_MEM  = wtag_q;
  assign write_data_L2_MEM = wdata_q;

endmodule

// File: tb/tb_l2_mem_requester.sv
// Self-checking bench for l2_mem_requester: expected refill lines are queued
// when a miss is presented and compared when refill_valid pulses.
// Define L2_MEM_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_l2_mem_requester;

  localparam int TNUM   = 22;
  localparam int INUM   = 26 - TNUM;
  localparam int LINE_W = 512;
  localparam int GAP_CYC = 2;
`ifdef L2_MEM_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              miss_req;
  logic [TNUM-1:0]   miss_tag;
  logic [INUM-1:0]   miss_index;
  logic              victim_dirty;
  logic [TNUM-1:0]   victim_tag;
  logic [LINE_W-1:0] victim_data;
  logic              miss_busy;
  logic              refill_valid;
  logic [LINE_W-1:0] refill_data;
  logic              read_L2_MEM;
  logic              write_L2_MEM;
  logic [TNUM-1:0]   tag_L2_MEM;
  logic [INUM-1:0]   index_L2_MEM;
  logic [TNUM-1:0]   write_tag_L2_MEM;
  logic [LINE_W-1:0] write_data_L2_MEM;
  logic              ready_MEM_L2;
  logic [LINE_W-1:0] read_data_MEM_L2;
  logic              timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned rv_count = 0;
  int unsigned rv_expect = 0;
  logic [LINE_W-1:0] sb[$];

  l2_mem_requester #(
    .TNUM(TNUM), .INUM(INUM), .LINE_W(LINE_W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .miss_req(miss_req), .miss_tag(miss_tag),
    .miss_index(miss_index), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_data(victim_data), .miss_busy(miss_busy), .refill_valid(refill_valid),
    .refill_data(refill_data), .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
    .write_tag_L2_MEM(write_tag_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
    .ready_MEM_L2(ready_MEM_L2), .read_data_MEM_L2(read_data_MEM_L2),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor on the falling edge: strobe exclusivity and scoreboard drain
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check("strobe_excl", LINE_W'(read_L2_MEM & write_L2_MEM), LINE_W'(0));
      if (refill_valid === 1'b1) begin
        rv_count++;
        if (sb.size() == 0) check("sb_unexpected_refill", LINE_W'(1), LINE_W'(0));
        else check("refill_data", refill_data, sb.pop_front());
      end
    end
  end

  task automatic present(input logic [TNUM-1:0] tag, input logic [INUM-1:0] idx,
                         input logic dirty, input logic [TNUM-1:0] vtag,
                         input logic [LINE_W-1:0] vdata, input logic [LINE_W-1:0] rdata,
                         input bit push);
    miss_req     = 1'b1;
    miss_tag     = tag;
    miss_index   = idx;
    victim_dirty = dirty;
    victim_tag   = vtag;
    victim_data  = vdata;
    if (push) begin
      sb.push_back(rdata);
      rv_expect++;
    end
  endtask

  // Drives one miss from acceptance to the DONE cycle, acting as memory
  task automatic run_txn(input logic [TNUM-1:0] tag, input logic [INUM-1:0] idx,
                         input logic dirty, input logic [TNUM-1:0] vtag,
                         input logic [LINE_W-1:0] vdata, input logic [LINE_W-1:0] rdata,
                         input int wb_lat, input int rd_lat, input bit spur_gap,
                         input bit hold_req);
    check("pre_accept_rd", LINE_W'(read_L2_MEM), LINE_W'(0));
    tick();
    if (!hold_req) miss_req = 1'b0;
    check("busy_accept", LINE_W'(miss_busy), LINE_W'(1));
    if (dirty) begin
      check("wb_strobe", LINE_W'(write_L2_MEM), LINE_W'(1));
      check("wb_rd_low", LINE_W'(read_L2_MEM), LINE_W'(0));
      check("wb_tag", LINE_W'(write_tag_L2_MEM), LINE_W'(vtag));
      check("wb_index", LINE_W'(index_L2_MEM), LINE_W'(idx));
      check("wb_data", write_data_L2_MEM, vdata);
      for (int i = 1; i < wb_lat; i++) begin
        tick();
        check("wb_hold", LINE_W'(write_L2_MEM), LINE_W'(1));
        check("wb_tag_hold", LINE_W'(write_tag_L2_MEM), LINE_W'(vtag));
      end
      ready_MEM_L2 = 1'b1;
      tick();
      ready_MEM_L2 = 1'b0;
      check("gap_wr_low", LINE_W'(write_L2_MEM), LINE_W'(0));
      check("gap_rd_low", LINE_W'(read_L2_MEM), LINE_W'(0));
      for (int g = 1; g < GAP_CYC; g++) begin
        if (spur_gap && g == 1) ready_MEM_L2 = 1'b1;
        tick();
        ready_MEM_L2 = 1'b0;
        check("gap_wr_low", LINE_W'(write_L2_MEM), LINE_W'(0));
        check("gap_rd_low", LINE_W'(read_L2_MEM), LINE_W'(0));
        check("gap_no_refill", LINE_W'(refill_valid), LINE_W'(0));
      end
      tick();
    end
    check("rd_strobe", LINE_W'(read_L2_MEM), LINE_W'(1));
    check("rd_wr_low", LINE_W'(write_L2_MEM), LINE_W'(0));
    check("rd_tag", LINE_W'(tag_L2_MEM), LINE_W'(tag));
    check("rd_index", LINE_W'(index_L2_MEM), LINE_W'(idx));
    for (int i = 1; i < rd_lat; i++) begin
      tick();
      check("rd_hold", LINE_W'(read_L2_MEM), LINE_W'(1));
      check("rd_wr_never", LINE_W'(write_L2_MEM), LINE_W'(0));
    end
    read_data_MEM_L2 = rdata;
    ready_MEM_L2 = 1'b1;
    tick();
    ready_MEM_L2 = 1'b0;
    read_data_MEM_L2 = rand_line();
    check("done_valid", LINE_W'(refill_valid), LINE_W'(1));
    check("done_rd_low", LINE_W'(read_L2_MEM), LINE_W'(0));
    check("done_data", refill_data, rdata);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_11, r1, r2, r3, r4;
    for (int i = 0; i < LINE_W / 8; i++) begin
      pat_a5[i*8 +: 8] = 8'hA5;
      pat_11[i*8 +: 8] = 8'h11;
    end
    rstn = 1'b0; miss_req = 1'b0; miss_tag = '0; miss_index = '0;
    victim_dirty = 1'b0; victim_tag = '0; victim_data = '0;
    ready_MEM_L2 = 1'b0; read_data_MEM_L2 = '0;
    tick(); tick();
    check("rst_busy", LINE_W'(miss_busy), LINE_W'(0));
    check("rst_rd", LINE_W'(read_L2_MEM), LINE_W'(0));
    check("rst_wr", LINE_W'(write_L2_MEM), LINE_W'(0));
    check("rst_valid", LINE_W'(refill_valid), LINE_W'(0));
    check("rst_refill", refill_data, LINE_W'(0));
    check("rst_tag", LINE_W'(tag_L2_MEM), LINE_W'(0));
    check("rst_wdata", write_data_L2_MEM, LINE_W'(0));
    check("rst_terr", LINE_W'(timeout_err), LINE_W'(0));
    rstn = 1'b1;
    tick();

    // Spurious ready in IDLE
    ready_MEM_L2 = 1'b1;
    tick();
    ready_MEM_L2 = 1'b0;
    check("idle_spur_busy", LINE_W'(miss_busy), LINE_W'(0));
    check("idle_spur_valid", LINE_W'(refill_valid), LINE_W'(0));

    // Clean miss
    present(22'h3ABCD, 4'h5, 1'b0, 22'h0, '0, pat_a5, 1'b1);
    run_txn(22'h3ABCD, 4'h5, 1'b0, 22'h0, '0, pat_a5, 0, 10, 1'b0, 1'b0);
    tick();
    check("clean_idle", LINE_W'(miss_busy), LINE_W'(0));
    check("clean_pulse_end", LINE_W'(refill_valid), LINE_W'(0));
    check("addr_hold", LINE_W'(tag_L2_MEM), LINE_W'(22'h3ABCD));
    check("data_hold", refill_data, pat_a5);

    // Dirty miss with a spurious ready in GAP
    r1 = rand_line();
    present(22'h2F00F, 4'h9, 1'b1, 22'h12345, pat_11, r1, 1'b1);
    run_txn(22'h2F00F, 4'h9, 1'b1, 22'h12345, pat_11, r1, 4, 3, 1'b1, 1'b0);
    tick();
    check("dirty_idle", LINE_W'(miss_busy), LINE_W'(0));

    // Back-to-back clean misses, miss_req held high throughout
    r2 = rand_line();
    r3 = rand_line();
    present(22'h00111, 4'h1, 1'b0, 22'h0, '0, r2, 1'b1);
    run_txn(22'h00111, 4'h1, 1'b0, 22'h0, '0, r2, 0, 2, 1'b0, 1'b1);
    present(22'h00222, 4'h2, 1'b0, 22'h0, '0, r3, 1'b1);
    tick();
    check("b2b_idle_gap", LINE_W'(miss_busy), LINE_W'(0));
    run_txn(22'h00222, 4'h2, 1'b0, 22'h0, '0, r3, 0, 1, 1'b0, 1'b0);
    tick();
    check("b2b_end_idle", LINE_W'(miss_busy), LINE_W'(0));

    // Reset in the middle of RD
    present(22'h0BEEF, 4'h7, 1'b0, 22'h0, '0, '0, 1'b0);
    tick();
    miss_req = 1'b0;
    check("rstmid_rd", LINE_W'(read_L2_MEM), LINE_W'(1));
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rstmid_rd_low", LINE_W'(read_L2_MEM), LINE_W'(0));
    check("rstmid_wr_low", LINE_W'(write_L2_MEM), LINE_W'(0));
    check("rstmid_busy", LINE_W'(miss_busy), LINE_W'(0));
    check("rstmid_refill", refill_data, LINE_W'(0));
    tick();
    check("rstmid_stay_idle", LINE_W'(miss_busy), LINE_W'(0));

    // Dirty miss with single-cycle memory responses after the reset
    r4 = rand_line();
    present(22'h3FFFF, 4'hF, 1'b1, 22'h2AAAA, r2, r4, 1'b1);
    run_txn(22'h3FFFF, 4'hF, 1'b1, 22'h2AAAA, r2, r4, 1, 1, 1'b0, 1'b0);
    tick();
    check("fast_idle", LINE_W'(miss_busy), LINE_W'(0));

`ifdef L2_MEM_TIMEOUT_EN
    // Memory never answers: watchdog aborts the read
    present(22'h01234, 4'h3, 1'b0, 22'h0, '0, '0, 1'b0);
    tick();
    miss_req = 1'b0;
    for (int c = 1; c <= TO_CYC; c++) begin
      check("to_rd_active", LINE_W'(read_L2_MEM), LINE_W'(1));
      check("to_err_low", LINE_W'(timeout_err), LINE_W'(0));
      tick();
    end
    check("to_err_set", LINE_W'(timeout_err), LINE_W'(1));
    check("to_rd_drop", LINE_W'(read_L2_MEM), LINE_W'(0));
    check("to_idle", LINE_W'(miss_busy), LINE_W'(0));
    repeat (3) tick();
    check("to_err_sticky", LINE_W'(timeout_err), LINE_W'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("to_err_reset", LINE_W'(timeout_err), LINE_W'(0));
`else
    check("terr_tied", LINE_W'(timeout_err), LINE_W'(0));
`endif

    repeat (2) tick();
    check("sb_drain", LINE_W'(sb.size()), LINE_W'(0));
    check("refill_count", LINE_W'(rv_count), LINE_W'(rv_expect));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
